// File: rtl/xalu_div_engine_if.sv
// Shared types for the XALU divide path and the FIFO/result bus between the IU side
// and the divider.
package xalu_div_pkg;
  localparam int NTHREADIDMSB = 2;
  localparam bit LUTRAMPROT   = 1'b1;

  localparam logic [1:0] c_UDIV = 2'd0;
  localparam logic [1:0] c_SDIV = 2'd1;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic [NTHREADIDMSB:0] tid;
    logic [31:0]           op1;
    logic [31:0]           op2;
    logic [1:0]            mode;
  } xalu_in_fifo_type;

  typedef struct packed {
    logic [31:0] y;
  } y_reg_type;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] y;
    logic        n;
    logic        z;
    logic        v;
    logic        parity;
  } xalu_fu_data_type;

  typedef struct packed {
    logic                  valid;
    logic [NTHREADIDMSB:0] tid;
    xalu_fu_data_type      data;
  } xalu_fu_out_type;
endpackage

interface xalu_div_engine_if;
  import xalu_div_pkg::*;

  xalu_in_fifo_type din;
  y_reg_type        yin;
  logic             en;
  logic             re;
  xalu_fu_out_type  dout;

  modport master (output din, output yin, output en, input re, input dout);
  modport slave  (input din, input yin, input en, output re, output dout);
endinterface

// File: rtl/xalu_div_engine.sv
// Sequential radix-2 restoring divider for SPARC V8 UDIV/SDIV: pops one request from
// the input FIFO, runs 32 shift-subtract steps and emits one tagged, saturated result.
module xalu_div_engine
  import xalu_div_pkg::*;
(
  input iu_clk_type        gclk,
  input logic              rst,
  xalu_div_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_re;
  logic                  w_done_entry;

  logic [NTHREADIDMSB:0] r_tid;
  logic [31:0]           r_op1;
  logic [31:0]           r_op2;
  logic [31:0]           r_y;
  logic                  r_signed;
  logic                  r_neg;
  logic [31:0]           r_rem;
  logic [31:0]           r_quo;
  logic [31:0]           r_div;
  logic [4:0]            r_cnt;
  xalu_fu_out_type       r_dout;

  logic [63:0]           w_dividend;
  logic [63:0]           w_abs_dividend;
  logic [31:0]           w_abs_divisor;
  logic                  w_ovf_early;
  logic [32:0]           w_win;
  logic                  w_qbit;
  logic [31:0]           w_rem_next;
  logic [31:0]           w_q_iter;
  logic                  w_ovf_in;
  logic [31:0]           w_q;
  logic [31:0]           w_res;
  logic                  w_v;
  logic                  w_n;
  logic                  w_z;
  logic                  w_par;

  always_ff @(posedge gclk.clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_re         = 1'b0;
    w_done_entry = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.en) begin
          w_re         = 1'b1;
          w_state_next = PREP;
        end
      end
      PREP: begin
        w_done_entry = w_ovf_early;
        w_state_next = w_ovf_early ? DONE : ITER;
      end
      ITER: begin
        if (r_cnt == 5'd31) begin
          w_done_entry = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.en) begin
          w_re         = 1'b1;
          w_state_next = PREP;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (rst) w_re = 1'b0;
  end

  // Magnitudes are taken once in PREP; the iteration itself is purely unsigned.
  assign w_dividend     = {r_y, r_op1};
  assign w_abs_dividend = (r_signed && w_dividend[63]) ? -w_dividend : w_dividend;
  assign w_abs_divisor  = (r_signed && r_op2[31]) ? -r_op2 : r_op2;
  assign w_ovf_early    = (w_abs_dividend[63:32] >= w_abs_divisor);

  // The partial remainder always stays below the divisor, so the difference fits 32 bits.
  assign w_win      = {r_rem, r_quo[31]};
  assign w_qbit     = (w_win >= {1'b0, r_div});
  assign w_rem_next = w_qbit ? (w_win[31:0] - r_div) : w_win[31:0];
  assign w_q_iter   = {r_quo[30:0], w_qbit};

  assign w_ovf_in = (r_state == PREP);
  assign w_q      = w_ovf_in ? 32'd0 : w_q_iter;

  always_comb begin
    w_res = w_q;
    w_v   = 1'b0;
    if (!r_signed) begin
      if (w_ovf_in) begin
        w_res = 32'hFFFF_FFFF;
        w_v   = 1'b1;
      end
    end else if (!r_neg) begin
      if (w_ovf_in || (w_q > 32'h7FFF_FFFF)) begin
        w_res = 32'h7FFF_FFFF;
        w_v   = 1'b1;
      end
    end else begin
      if (w_ovf_in || (w_q > 32'h8000_0000)) begin
        w_res = 32'h8000_0000;
        w_v   = 1'b1;
      end else begin
        w_res = -w_q;
      end
    end
    w_n   = w_res[31];
    w_z   = (w_res == 32'd0);
    w_par = LUTRAMPROT ? ^{w_res, w_n, w_z, w_v} : 1'b0;
  end

  always_ff @(posedge gclk.clk) begin
    if (rst) begin
      r_tid    <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_y      <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
    end else begin
      if (w_re) begin
        r_tid    <= bus.din.tid;
        r_op1    <= bus.din.op1;
        r_op2    <= bus.din.op2;
        r_y      <= bus.yin.y;
        r_signed <= (bus.din.mode == c_SDIV);
        r_neg    <= (bus.din.mode == c_SDIV) & (bus.yin.y[31] ^ bus.din.op2[31]);
      end
      case (r_state)
        PREP: begin
          r_rem <= w_abs_dividend[63:32];
          r_quo <= w_abs_dividend[31:0];
          r_div <= w_abs_divisor;
          r_cnt <= '0;
        end
        ITER: begin
          r_rem <= w_rem_next;
          r_quo <= w_q_iter;
          r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
      r_dout.valid <= w_done_entry;
      if (w_done_entry) begin
        r_dout.tid         <= r_tid;
        r_dout.data.res    <= w_res;
        r_dout.data.y      <= 32'd0;
        r_dout.data.n      <= w_n;
        r_dout.data.z      <= w_z;
        r_dout.data.v      <= w_v;
        r_dout.data.parity <= w_par;
      end
    end
  end

  assign bus.re   = w_re;
  assign bus.dout = r_dout;

endmodule

// File: tb/tb_xalu_div_engine.sv
// Self-checking bench for xalu_div_engine: directed cases plus random requests
// compared against an arithmetic reference model with cycle-accurate result timing.
module tb_xalu_div_engine;
  import xalu_div_pkg::*;

  iu_clk_type gclk;
  logic       rst;

  xalu_div_engine_if bus();

  xalu_div_engine dut (
    .gclk (gclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial gclk.clk = 1'b0;
  always #5 gclk.clk = ~gclk.clk;

  typedef struct {
    logic [NTHREADIDMSB:0] tid;
    logic [31:0]           y;
    logic [31:0]           op1;
    logic [31:0]           op2;
    logic [1:0]            mode;
  } req_t;

  typedef struct {
    logic [NTHREADIDMSB:0] tid;
    logic [31:0]           res;
    logic                  v;
    int                    due;
  } exp_t;

  req_t fifo_q[$];
  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   last_pop  = -1;
  bit   after_rst = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  // Reference: plain magnitude division, then saturation by sign.
  function automatic exp_t model(input req_t r, input int now);
    exp_t        e;
    logic [63:0] dd;
    logic [63:0] md;
    logic [63:0] qm;
    logic [31:0] dv;
    bit          s;
    bit          neg;
    bit          big;
    s   = (r.mode == c_SDIV);
    dd  = {r.y, r.op1};
    neg = s && (dd[63] != r.op2[31]);
    md  = (s && dd[63]) ? -dd : dd;
    dv  = (s && r.op2[31]) ? -r.op2 : r.op2;
    big = (dv == 32'd0);
    qm  = big ? 64'd0 : md / {32'd0, dv};
    if (qm > 64'hFFFF_FFFF) big = 1'b1;
    e.res = qm[31:0];
    e.v   = 1'b0;
    if (!s) begin
      if (big) begin
        e.res = 32'hFFFF_FFFF;
        e.v   = 1'b1;
      end
    end else if (!neg) begin
      if (big || qm > 64'h7FFF_FFFF) begin
        e.res = 32'h7FFF_FFFF;
        e.v   = 1'b1;
      end
    end else begin
      if (big || qm > 64'h8000_0000) begin
        e.res = 32'h8000_0000;
        e.v   = 1'b1;
      end else begin
        e.res = 32'd0 - qm[31:0];
      end
    end
    e.tid = r.tid;
    e.due = now + (big ? 2 : 34);
    return e;
  endfunction

  task automatic push(input int tid, input logic [31:0] y, input logic [31:0] op1,
                      input logic [31:0] op2, input logic [1:0] mode);
    req_t r;
    r.tid  = tid[NTHREADIDMSB:0];
    r.y    = y;
    r.op1  = op1;
    r.op2  = op2;
    r.mode = mode;
    fifo_q.push_back(r);
  endtask

  // One clock cycle: check outputs from the last edge, drive inputs, check re, advance.
  task automatic step(input bit r, input bit gate);
    exp_t e;
    req_t h;
    bit   want_re;
    logic par;
    if (after_rst) begin
      check("rst_dout", bus.dout, 128'd0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e   = exp_q.pop_front();
      par = LUTRAMPROT ? ^{e.res, e.res[31], (e.res == 32'd0), e.v} : 1'b0;
      check("valid",  bus.dout.valid, 1'b1);
      check("tid",    bus.dout.tid, e.tid);
      check("res",    bus.dout.data.res, e.res);
      check("n",      bus.dout.data.n, e.res[31]);
      check("z",      bus.dout.data.z, (e.res == 32'd0));
      check("v",      bus.dout.data.v, e.v);
      check("y",      bus.dout.data.y, 32'd0);
      check("parity", bus.dout.data.parity, par);
      $display("result cycle=%0d tid=%0d res=%08h v=%0d", cyc, bus.dout.tid,
               bus.dout.data.res, bus.dout.data.v);
    end else begin
      check("idle_valid", bus.dout.valid, 1'b0);
    end

    rst    = r;
    bus.en = gate && (fifo_q.size() > 0);
    if (fifo_q.size() > 0) begin
      h            = fifo_q[0];
      bus.din.tid  = h.tid;
      bus.din.op1  = h.op1;
      bus.din.op2  = h.op2;
      bus.din.mode = h.mode;
      bus.yin.y    = h.y;
    end
    #1;
    want_re = bus.en && !r && (exp_q.size() == 0);
    check("re", bus.re, want_re);
    if (bus.re === 1'b1 && fifo_q.size() > 0) begin
      exp_q.push_back(model(h, cyc));
      void'(fifo_q.pop_front());
      last_pop = cyc;
    end
    if (r) exp_q.delete();
    after_rst = r;
    @(posedge gclk.clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int maxc, input int gate_pct);
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
      step(1'b0, ($urandom_range(0, 99) < gate_pct));
      n++;
    end
    check("drain_pending", fifo_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int target;
    int n;
    int sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] y;

    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.din = '0;
    bus.yin = '0;
    repeat (2) @(posedge gclk.clk);
    #1;
    after_rst = 1'b1;

    // Directed cases; first entry is visible during reset so re gating is exercised.
    push(3, 32'h0, 32'd100, 32'd7, c_UDIV);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    push(4, 32'd5, 32'h1234_5678, 32'd5, c_UDIV);
    push(0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2, c_SDIV);
    push(7, 32'h0, 32'd7, 32'hFFFF_FFFE, c_SDIV);
    push(2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, c_SDIV);
    push(5, 32'h0, 32'd0, 32'd5, c_SDIV);
    push(1, 32'h0, 32'd1000, 32'd10, c_UDIV);
    push(6, 32'h0, 32'd12345678, 32'd321, c_UDIV);
    push(3, 32'h0, 32'd99, 32'd0, c_UDIV);
    push(4, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'd0, c_SDIV);
    push(2, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2);
    push(1, 32'hFFFF_FFFF, 32'd40, 32'd3, 2'd3);
    push(0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, c_SDIV);
    drain(2000, 100);

    // Reset during the 10th ITER cycle drops the in-flight op.
    push(2, 32'h0, 32'd1000, 32'd3, c_UDIV);
    push(5, 32'h0, 32'd77, 32'd7, c_UDIV);
    last_pop = -1;
    n = 0;
    while (last_pop < 0 && n < 50) begin
      step(1'b0, 1'b1);
      n++;
    end
    check("rst_pop_seen", (last_pop >= 0), 1'b1);
    target = last_pop + 11;
    while (cyc < target) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    drain(200, 100);

    // Random requests with intermittent FIFO-empty gaps.
    for (int i = 0; i < 40; i++) begin
      op1 = $urandom;
      case ($urandom_range(0, 7))
        0:       op2 = 32'd0;
        1:       op2 = $urandom_range(1, 15);
        2:       op2 = 32'hFFFF_FFFF;
        default: op2 = $urandom;
      endcase
      sel = $urandom_range(0, 3);
      case (sel)
        0:       y = 32'd0;
        1:       y = {32{op1[31]}};
        2:       y = $urandom_range(0, 3);
        default: y = $urandom;
      endcase
      push($urandom_range(0, 7), y, op1, op2, 2'($urandom_range(0, 3)));
    end
    drain(5000, 75);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
